// File: rtl/pipelined_segment_adder.sv
// Purpose : WIDTH-bit add/subtract split into SEG_WIDTH-bit segments, one segment per
//           pipeline stage, carry registered between stages; reports signed overflow.
// Latency : STAGES = WIDTH/SEG_WIDTH enabled clocks from sampling edge to o_valid.
// Backpr. : i_stall freezes every register (outputs hold); operands offered while
//           stalled are dropped, so the upstream must hold them. No skid buffer.
// Ports   : i_clk / i_rst_n (sync, active-low) ; i_valid, i_stall, i_sub,
//           i_add1, i_add2 operands ; o_valid, o_result {carry, sum}, o_overflow.
module pipelined_segment_adder #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic             o_valid,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int STAGES = (SEG_WIDTH < 1) ? 1 : WIDTH / SEG_WIDTH;
  localparam int LAST   = STAGES - 1;

  if (SEG_WIDTH < 1) begin : g_bad_seg
    $error("pipelined_segment_adder: SEG_WIDTH must be at least 1");
  end else if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_width
    $error("pipelined_segment_adder: WIDTH must be a multiple of SEG_WIDTH");
  end

  // Per-stage registers. a/b carry the full operand so higher segments are
  // skewed forward to their stage; sum accumulates finished lower segments so
  // the complete result leaves the last stage aligned.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;

  // Stage inputs: stage 0 takes the ports, stage s takes stage s-1's registers.
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [STAGES-1:0] st_cy;
  logic [STAGES-1:0] st_vld;
  logic [SEG_WIDTH:0] seg_sum;

  always_comb begin
    st_a[0]   = i_add1;
    st_b[0]   = i_sub ? ~i_add2 : i_add2;
    st_cy[0]  = i_sub;            // +1 completes the two's complement for subtract
    st_vld[0] = i_valid;
    st_sum[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_cy[s]  = cy_q[s-1];
      st_vld[s] = vld_q[s-1];
      st_sum[s] = sum_q[s-1];
    end

    // Hold everything by default; this is the stall behaviour.
    vld_d   = vld_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    seg_sum = '0;

    if (!i_stall) begin
      for (int s = 0; s < STAGES; s++) begin
        seg_sum = {1'b0, st_a[s][s*SEG_WIDTH +: SEG_WIDTH]}
                + {1'b0, st_b[s][s*SEG_WIDTH +: SEG_WIDTH]}
                + {{SEG_WIDTH{1'b0}}, st_cy[s]};
        vld_d[s] = st_vld[s];
        cy_d[s]  = seg_sum[SEG_WIDTH];
        a_d[s]   = st_a[s];
        b_d[s]   = st_b[s];
        sum_d[s] = st_sum[s];
        sum_d[s][s*SEG_WIDTH +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
      end
      // Signed overflow: operands share a sign and the result's sign differs.
      ovf_d = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
              (sum_d[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  assign o_valid    = vld_q[LAST];
  assign o_result   = {cy_q[LAST], sum_q[LAST]};
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_segment_adder.sv
module tb_pipelined_segment_adder;

  localparam int WIDTH  = 16;
  localparam int SEG    = 4;
  localparam int STAGES = WIDTH / SEG;

  logic              clk = 1'b0;
  logic              rst_n, valid, stall, sub;
  logic [WIDTH-1:0]  add1, add2;
  logic              o_valid, o_overflow;
  logic [WIDTH:0]    o_result;

  always #5 clk = ~clk;

  pipelined_segment_adder #(.WIDTH(WIDTH), .SEG_WIDTH(SEG)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_stall    (stall),
    .i_sub      (sub),
    .i_add1     (add1),
    .i_add2     (add2),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_overflow (o_overflow)
  );

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] res;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [16:0] res;
    logic        ov;
    int          due;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         head;
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  logic [16:0] exp_res = '0;
  logic        exp_ov  = 1'b0;
  logic [18:0] prev_out = '0;
  logic [18:0] cur_out;
  bit          rst_edge, en_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Whole-word reference: {overflow, carry, sum}.
  function automatic logic [17:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eb;
    logic [16:0] r;
    logic        ov;
    eb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, eb} + {16'd0, s};
    ov = (a[15] == eb[15]) && (r[15] != a[15]);
    return {ov, r};
  endfunction

  // Monitor / scoreboard. Pushes at the edge the DUT samples an operand, and
  // expects it STAGES-1 enabled edges later (visible just after that edge).
  always @(posedge clk) begin
    rst_edge = !rst_n;
    en_edge  = rst_n && !stall;
    if (rst_edge) begin
      sb_q.delete();
    end else if (en_edge) begin
      en_cnt++;
      if (valid) sb_q.push_back('{exp_res, exp_ov, en_cnt + STAGES - 1});
    end
    #1;
    cur_out = {o_valid, o_overflow, o_result};
    if (rst_edge) begin
      check("reset_state", 32'(cur_out), 32'(0));
    end else if (en_edge) begin
      if (o_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual o_valid=1 required o_valid=0 (t=%0t)", $time);
        end else begin
          head = sb_q.pop_front();
          check("latency_edge", 32'(en_cnt), 32'(head.due));
          check("result", 32'(o_result), 32'(head.res));
          check("overflow", 32'(o_overflow), 32'(head.ov));
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= en_cnt) begin
        checks++;
        errors++;
        $display("FAIL missing_result actual o_valid=0 required o_valid=1 res=%0h (t=%0t)",
                 sb_q[0].res, $time);
        void'(sb_q.pop_front());
      end
    end else begin
      check("stall_hold", 32'(cur_out), 32'(prev_out));
    end
    prev_out = cur_out;
  end

  task automatic op_x(input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [16:0] r, input logic ov);
    @(posedge clk);
    #1;
    stall   = 1'b0;
    valid   = 1'b1;
    sub     = s;
    add1    = a;
    add2    = b;
    exp_res = r;
    exp_ov  = ov;
  endtask

  task automatic op(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [17:0] m;
    m = model(s, a, b);
    op_x(s, a, b, m[16:0], m[17]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid = 1'b0;
      stall = 1'b0;
    end
  endtask

  // Stall with a valid operand offered; it must be dropped.
  task automatic stall_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      stall = 1'b1;
      valid = 1'b1;
      sub   = 1'b0;
      add1  = 16'($urandom);
      add2  = 16'($urandom);
    end
  endtask

  task automatic do_reset(input logic with_stall);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stall = with_stall;
    valid = 1'b1;
    add1  = 16'h1111;
    add2  = 16'h2222;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    vec_t        tbl [10];
    logic [15:0] lfsr, a, b;

    rst_n = 1'b0;
    valid = 1'b0;
    stall = 1'b0;
    sub   = 1'b0;
    add1  = '0;
    add2  = '0;

    tbl[0] = '{1'b0, 16'h0000, 16'h0001, 17'h00001, 1'b0};
    tbl[1] = '{1'b0, 16'h0002, 16'hFFFE, 17'h10000, 1'b0};
    tbl[2] = '{1'b0, 16'hFFFD, 16'hFFFE, 17'h1FFFB, 1'b0};
    tbl[3] = '{1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
    tbl[4] = '{1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1};
    tbl[5] = '{1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b1};
    tbl[6] = '{1'b1, 16'h0005, 16'h0007, 17'h0FFFE, 1'b0};
    tbl[7] = '{1'b1, 16'h0007, 16'h0005, 17'h10002, 1'b0};
    tbl[8] = '{1'b1, 16'h8000, 16'h0001, 17'h17FFF, 1'b1};
    tbl[9] = '{1'b0, 16'h0FFF, 16'h0001, 17'h01000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single operations with gaps.
    for (int i = 0; i < 10; i++) begin
      op_x(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ov);
      idle(5);
    end

    // Back-to-back stream, alternating add/sub, LFSR operands.
    lfsr = 16'hACE1;
    op(1'b0, 16'h0FFF, 16'h0001);
    for (int i = 1; i < 8; i++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      a    = lfsr;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      b    = lfsr;
      op(i[0], a, b);
    end
    idle(6);

    // Stall mid-stream with operands offered, then a bubble.
    op(1'b0, 16'h1234, 16'h1111);
    op(1'b1, 16'h0100, 16'h0200);
    stall_cyc(3);
    op(1'b0, 16'h7FF0, 16'h0010);
    idle(1);
    op(1'b1, 16'h8000, 16'h7FFF);
    idle(8);

    // Reset with operations in flight.
    op(1'b0, 16'h4444, 16'h3333);
    op(1'b1, 16'h0001, 16'h0002);
    do_reset(1'b0);
    op(1'b0, 16'h7FFF, 16'h0001);
    idle(6);

    // Reset while stalled still clears.
    op(1'b0, 16'hAAAA, 16'h5555);
    op(1'b1, 16'h0003, 16'h0009);
    stall_cyc(1);
    do_reset(1'b1);
    idle(1);
    op(1'b1, 16'h0000, 16'h0001);
    idle(8);

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
